// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings, branch funct3 codes and requester IDs
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;
    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_AG = 1'b1;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU with branch comparison on funct3
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] result,
    output logic            branch
);
    logic lt, ltu;
    assign lt  = $signed(in1) < $signed(in2);
    assign ltu = in1 < in2;
    // Arithmetic/logic result selected by the full 4-bit control
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = in1 + in2;
            ALU_SUB:  result = in1 - in2;
            ALU_SLL:  result = in1 << in2[4:0];
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            ALU_XOR:  result = in1 ^ in2;
            ALU_SRL:  result = in1 >> in2[4:0];
            ALU_SRA:  result = $signed(in1) >>> in2[4:0];
            ALU_OR:   result = in1 | in2;
            ALU_AND:  result = in1 & in2;
            default:  result = '0;
        endcase
    end
    // Branch condition from funct3; codes 010/011 have no branch meaning and give 0
    always_comb begin
        branch = 1'b0;
        case (ctrl[2:0])
            BR_BEQ:  branch = in1 == in2;
            BR_BNE:  branch = in1 != in2;
            BR_BLT:  branch = lt;
            BR_BGE:  branch = !lt;
            BR_BLTU: branch = ltu;
            BR_BGEU: branch = !ltu;
            default: branch = 1'b0;
        endcase
    end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, qualified by response slot availability
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  logic       slot_free,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    // On contention the requester that did not win last time goes first
    always_comb begin
        gnt_idx = (valid0 && valid1) ? !last : valid1;
        gnt[0]  = slot_free && valid0 && !gnt_idx;
        gnt[1]  = slot_free && valid1 && gnt_idx;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with a registered response; ALU_ARB_STATS_EN adds counters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [XLEN-1:0]  req0_in1,
    input  logic [XLEN-1:0]  req0_in2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [XLEN-1:0]  req1_in1,
    input  logic [XLEN-1:0]  req1_in2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_branch
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_grant0,
    output logic [CNT_W-1:0] stat_grant1,
    output logic [CNT_W-1:0] stat_conflict
`endif
);
    logic            slot_free, gnt_idx, last, alu_br, accept;
    logic [1:0]      gnt;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    assign slot_free  = !rsp_valid || rsp_ready;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;
    rr_arb2 u_arb (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .last      (last),
        .slot_free (slot_free),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );
    // Steer the granted requester's operation onto the shared ALU
    always_comb begin
        alu_ctrl = gnt_idx ? req1_ctrl : req0_ctrl;
        alu_a    = gnt_idx ? req1_in1  : req0_in1;
        alu_b    = gnt_idx ? req1_in2  : req0_in2;
    end
    alu #(.XLEN(XLEN)) u_alu (
        .ctrl   (alu_ctrl),
        .in1    (alu_a),
        .in2    (alu_b),
        .result (alu_res),
        .branch (alu_br)
    );
    // Response register: refill on accept, otherwise drain when consumed; priority rotates only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= REQ_EX;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
            last       <= REQ_AG;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_idx;
            rsp_result <= alu_res;
            rsp_branch <= alu_br;
            last       <= gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end
`ifdef ALU_ARB_STATS_EN
    // Saturating grant and contention counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (gnt[0] && !(&stat_grant0)) stat_grant0 <= stat_grant0 + CNT_W'(1);
            if (gnt[1] && !(&stat_grant1)) stat_grant1 <= stat_grant1 + CNT_W'(1);
            if (req0_valid && req1_valid && slot_free && !(&stat_conflict))
                stat_conflict <= stat_conflict + CNT_W'(1);
        end
    end
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (stats checks when ALU_ARB_STATS_EN is defined)
module tb_alu_arbiter;
    localparam int CW = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
    logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic [31:0] req0_in1 = 0, req0_in2 = 0, req1_in1 = 0, req1_in2 = 0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_branch;
    logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
    logic [CW-1:0] stat_grant0, stat_grant1, stat_conflict;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_branch(rsp_branch)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic op0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_ctrl = c; req0_in1 = a; req0_in2 = b;
    endtask

    task automatic op1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_ctrl = c; req1_in1 = a; req1_in2 = b;
    endtask

    initial begin
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_branch", rsp_branch, 0);
        tick();
        rst = 1'b0;
        chk("idle_ready0", req0_ready, 0);
        chk("idle_ready1", req1_ready, 0);

        op0(1, 4'b0000, 5, 7);
        #1;
        chk("add_ready0", req0_ready, 1);
        chk("add_ready1", req1_ready, 0);
        tick();
        op0(0, 0, 0, 0);
        chk("add_valid", rsp_valid, 1);
        chk("add_id", rsp_id, 0);
        chk("add_result", rsp_result, 12);
        tick();
        chk("drain_valid", rsp_valid, 0);
        chk("drain_hold", rsp_result, 12);

        pulse_rst();
        op0(1, 4'b1000, 3, 5);
        op1(1, 4'b0100, 32'hFFFF_FFFF, 1);
        #1;
        chk("cont_ready0", req0_ready, 1);
        chk("cont_ready1", req1_ready, 0);
        tick();
        chk("cont_id0", rsp_id, 0);
        chk("cont_sub", rsp_result, 32'hFFFF_FFFE);
        chk("cont_beq", rsp_branch, 0);
        chk("cont_ready1b", req1_ready, 1);
        tick();
        chk("cont_id1", rsp_id, 1);
        chk("cont_blt", rsp_branch, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("alt_id%0d", i), rsp_id, (i % 2 == 0) ? 0 : 1);
            chk($sformatf("alt_valid%0d", i), rsp_valid, 1);
        end
        op0(0, 0, 0, 0);
        op1(0, 0, 0, 0);
        tick();

        op0(1, 4'b0010, 32'hFFFF_FFFD, 2);
        tick();
        chk("slt", rsp_result, 1);
        op0(1, 4'b0011, 32'hFFFF_FFFD, 2);
        tick();
        chk("sltu", rsp_result, 0);
        op0(1, 4'b0000, 1, 2);
        tick();
        op0(0, 0, 0, 0);
        chk("bp_pre", rsp_result, 3);
        rsp_ready = 1'b0;
        op1(1, 4'b1101, 32'h8000_0000, 4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready0_%0d", i), req0_ready, 0);
            chk($sformatf("bp_ready1_%0d", i), req1_ready, 0);
            tick();
            chk($sformatf("bp_valid%0d", i), rsp_valid, 1);
            chk($sformatf("bp_result%0d", i), rsp_result, 3);
            chk($sformatf("bp_id%0d", i), rsp_id, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready1", req1_ready, 1);
        tick();
        op1(0, 0, 0, 0);
        chk("sra_result", rsp_result, 32'hF800_0000);
        chk("sra_id", rsp_id, 1);
        chk("sra_valid", rsp_valid, 1);
        tick();
        chk("sra_drain", rsp_valid, 0);

        op0(1, 4'b0000, 1, 1);
        tick();
        op0(0, 0, 0, 0);
        rsp_ready = 1'b0;
        chk("ar_pre", rsp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", rsp_valid, 0);
        chk("ar_result", rsp_result, 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        op0(1, 4'b0000, 9, 1);
        op1(1, 4'b0000, 4, 4);
        #1;
        chk("ar_ready0", req0_ready, 1);
        chk("ar_ready1", req1_ready, 0);
        tick();
        chk("ar_id", rsp_id, 0);
        chk("ar_sum", rsp_result, 10);
        op0(0, 0, 0, 0);
        op1(0, 0, 0, 0);
        tick();

`ifdef ALU_ARB_STATS_EN
        pulse_rst();
        #1;
        chk("st_rst", {stat_grant0, stat_grant1, stat_conflict}, 0);
        op0(1, 4'b0000, 1, 1);
        op1(1, 4'b0000, 2, 2);
        for (int i = 0; i < 10; i++) tick();
        chk("st_g0_10", stat_grant0, 5);
        chk("st_g1_10", stat_grant1, 5);
        chk("st_cf_10", stat_conflict, 10);
        for (int i = 0; i < 10; i++) tick();
        chk("st_g0_20", stat_grant0, 10);
        chk("st_cf_sat", stat_conflict, 15);
        for (int i = 0; i < 20; i++) tick();
        chk("st_g0_sat", stat_grant0, 15);
        chk("st_g1_sat", stat_grant1, 15);
        chk("st_cf_sat2", stat_conflict, 15);
        op0(0, 0, 0, 0);
        op1(0, 0, 0, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance (4-bit control `{esp_fun, funcion}`, two 32-bit operands, result plus branch flag) between two requesters.
  - Requester 0: execute stage.
  - Requester 1: branch/address-generation unit.
- Round-robin grant, valid/ready handshake on each request port.
- ALU result and branch flag are captured in a single-entry response register with its own valid/ready handshake.
- Sits between decode/issue and writeback in the multi-unit pipeline.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported by the instantiated ALU.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctrl  in  4  ALU control for requester 0.
- req0_in1  in  XLEN  operand 1 for requester 0.
- req0_in2  in  XLEN  operand 2 for requester 0.
- req1_valid, req1_ready, req1_ctrl, req1_in1, req1_in2: same as requester 0, for requester 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  XLEN  registered ALU result.
- rsp_branch  out  1  registered ALU branch flag.

Behaviour:
- Clock/reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_branch=0.
  - Round-robin pointer `last`=1, so requester 0 wins the first contention.
  - Counters = 0.
- Slot free: `slot_free = !rsp_valid || rsp_ready`. A same-cycle drain and refill is allowed.
- Grant (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than `last` wins.
  - No valid request means no grant.
- Ready: `reqX_ready = slot_free && grant==X`. Ready may depend on the valid inputs. A requester must not drop valid or change its payload while valid && !ready.
- Datapath: the granted requester's ctrl/in1/in2 are muxed onto the internal ALU. The ALU is purely combinational.
- Accept (reqX_valid && reqX_ready): on the next rising edge:
  - rsp_valid=1, rsp_id=X, rsp_result=ALU result, rsp_branch=ALU branch.
  - `last`=X.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Drain without a new accept: rsp_valid && rsp_ready clears rsp_valid. result/branch/id hold their last values.
- Backpressure: rsp_valid && !rsp_ready gives slot_free=0. Both readys are 0 and the response register holds stable.
- `last` updates only on an accept. A stalled grant does not rotate priority.
- Throughput: one operation per cycle when rsp_ready is held high. Under full contention, grants strictly alternate 0,1,0,1.
- Branch flag: rsp_branch is an undefined value for ALU function codes 010/011. Consumers ignore it except on branch operations. The bench masks it for those codes.
- Reset mid-operation: a pending response is discarded, rsp_valid drops immediately (asynchronous), and no handshake completes.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs `stat_grant0`, `stat_grant1` and `stat_conflict`, each CNT_W bits, in that port order after rsp_branch.
  - stat_grantX increments on each accept from requester X.
  - stat_conflict increments on each cycle where both valids are 1 and slot_free=1.
  - All counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package `alu_pkg`:
  - ALU control constants: ADD=4'b0000, SUB=4'b1000, SLL, SLT, SLTU, XOR, SRL, SRA=4'b1101, OR, AND.
  - Branch funct3 codes BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Requester ID constants REQ_EX=0, REQ_AG=1.
- Sub-module `rr_arb2`:
  - Inputs: two valids, `last`, `slot_free`.
  - Outputs: grant one-hot and grant index.
  - Purely combinational; `last` is registered in the parent.
- The ALU is instantiated once inside alu_arbiter.

Test Plan:
- Single add: req0 ctrl=0000, in1=5, in2=7, rsp_ready=1 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
- Contention after reset: both valid; req0 SUB 3-5, req1 BLT ctrl=0100 with in1=-1, in2=1 -> first response id=0 result=0xFFFFFFFE; next id=1 rsp_branch=1. Sustained contention alternates ids.
- Backpressure: rsp_ready=0 for 3 cycles with a response held and req1 valid -> both readys=0, rsp_result/rsp_id stable. On rsp_ready=1, req1 is accepted the same cycle, and its response appears next cycle.
- Shift: req1 SRA ctrl=1101, in1=0x80000000, in2=4 -> rsp_result=0xF8000000, rsp_id=1.
- Async reset mid-stall: with rsp_valid=1, assert rst between clock edges -> rsp_valid=0 immediately. After release, the first contention grants req0.
- ALU_ARB_STATS_EN defined: 10 contended accepts -> stat_grant0=5, stat_grant1=5, stat_conflict=10. Preload near saturation and verify the counters stick at 0xFFFF.
